// File: rtl/cnn_pkg.sv
// cnn_pkg: shared constants, sample type and collector state encoding.
// POOL_MAP_RELU_EN selects ReLU clamping of stored samples.
package cnn_pkg;
    localparam int N      = 32;
    localparam int DATA_W = 16;
    localparam int ADDR_W = $clog2(N * N);

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {IDLE, SETUP, CAPTURE, READY} pool_map_state_t;

    function automatic sample_t store_sample(input sample_t s);
`ifdef POOL_MAP_RELU_EN
        return s[DATA_W-1] ? '0 : s;
`else
        return s;
`endif
    endfunction
endpackage

// File: rtl/pool_map_ram.sv
// pool_map_ram: single write port, registered read port feature-map buffer.
module pool_map_ram
    import cnn_pkg::*;
#(
    parameter int DEPTH = N * N,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sample_t       wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output sample_t       rdata
);
    sample_t mem [DEPTH];
    sample_t rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_comb rdata_d = re ? mem[raddr] : rdata_q;

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata_q <= '0;
        else        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/pool_map_collector.sv
// pool_map_collector: captures pooled samples into a raster map and serves reads.
// Define POOL_MAP_RELU_EN to store negative samples as zero.
module pool_map_collector
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       imgSize,
    input  logic [15:0]       windowSize,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              rd_en,
    input  logic [15:0]       rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [15:0]       outSize,
    output logic              busy,
    output logic              map_ready,
    output logic              cfg_err,
    output logic              ovf_err
);
    pool_map_state_t state_q, state_d;
    logic [15:0] ws_q, ws_d, rem_q, rem_d, out_q, out_d, row_q, row_d, col_q, col_d;
    logic        cfg_q, cfg_d, ovf_q, ovf_d, rdv_q, rdv_d, oob_q, oob_d;
    logic        we, re, cfg_ok, last_col, in_range;
    logic [15:0] area;
    sample_t     ram_q;

    assign cfg_ok   = windowSize != 16'd0 && imgSize != 16'd0 && imgSize <= 16'(N);
    assign last_col = col_q == out_q - 16'd1;
    assign area     = out_q * out_q;
    assign in_range = rd_addr < area;

    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        rem_d   = rem_q;
        out_d   = out_q;
        row_d   = row_q;
        col_d   = col_q;
        cfg_d   = cfg_q;
        ovf_d   = ovf_q;
        oob_d   = oob_q;
        rdv_d   = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        if (start) begin
            row_d = '0;
            col_d = '0;
            if (cfg_ok) begin
                state_d = SETUP;
                ws_d    = windowSize;
                rem_d   = imgSize;
                out_d   = '0;
                cfg_d   = 1'b0;
                ovf_d   = 1'b0;
            end else begin
                state_d = IDLE;
                cfg_d   = 1'b1;
            end
        end else begin
            case (state_q)
                // Division by repeated subtraction: one window per cycle.
                SETUP: begin
                    out_d   = out_q + 16'd1;
                    rem_d   = rem_q > ws_q ? rem_q - ws_q : '0;
                    state_d = rem_q <= ws_q ? CAPTURE : SETUP;
                end
                CAPTURE: begin
                    if (in_valid) begin
                        we      = 1'b1;
                        col_d   = last_col ? '0 : col_q + 16'd1;
                        row_d   = last_col ? row_q + 16'd1 : row_q;
                        state_d = last_col && row_q == out_q - 16'd1 ? READY : CAPTURE;
                    end
                end
                default: ovf_d = ovf_q | in_valid;
            endcase
        end
        if (state_q == READY && rd_en) begin
            rdv_d = 1'b1;
            re    = in_range;
            oob_d = !in_range;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ws_q    <= '0;
            rem_q   <= '0;
            out_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            cfg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            rdv_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            rem_q   <= rem_d;
            out_q   <= out_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cfg_q   <= cfg_d;
            ovf_q   <= ovf_d;
            rdv_q   <= rdv_d;
            oob_q   <= oob_d;
        end
    end

    pool_map_ram #(.DEPTH(N * N), .AW(ADDR_W)) u_ram (
        .clk   (clk),
        .rst_n (reset),
        .we    (we),
        .waddr (ADDR_W'(row_q * out_q + col_q)),
        .wdata (store_sample(in_data)),
        .re    (re),
        .raddr (ADDR_W'(rd_addr)),
        .rdata (ram_q)
    );

    assign rd_data   = oob_q ? '0 : ram_q;
    assign rd_valid  = rdv_q;
    assign outSize   = out_q;
    assign busy      = state_q == SETUP || state_q == CAPTURE;
    assign map_ready = state_q == READY;
    assign cfg_err   = cfg_q;
    assign ovf_err   = ovf_q;
endmodule

// File: tb/tb_pool_map_collector.sv
// tb_pool_map_collector: randomized and directed checks against an array model of the map.
module tb_pool_map_collector;
    import cnn_pkg::*;

    logic        clk = 0, reset = 0, start = 0, in_valid = 0, rd_en = 0;
    logic [15:0] imgSize = 0, windowSize = 0, rd_addr = 0, outSize;
    logic [15:0] in_data = 0, rd_data;
    logic        rd_valid, busy, map_ready, cfg_err, ovf_err;
    int          checks = 0, errors = 0, os = 0;
    logic [15:0] model [N*N];
    logic [15:0] q [$];
    logic [15:0] held;

    always #5 clk = ~clk;

    pool_map_collector dut (
        .clk(clk), .reset(reset), .start(start), .imgSize(imgSize), .windowSize(windowSize),
        .in_valid(in_valid), .in_data(in_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .outSize(outSize), .busy(busy),
        .map_ready(map_ready), .cfg_err(cfg_err), .ovf_err(ovf_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] kept(input logic [15:0] v);
`ifdef POOL_MAP_RELU_EN
        return $signed(v) < 0 ? 16'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {rd_data, rd_valid, outSize, busy, map_ready, cfg_err, ovf_err}, '0);
    endtask

    task automatic begin_map(input int img, input int ws);
        imgSize = 16'(img);
        windowSize = 16'(ws);
        start = 1;
        tick();
        start = 0;
        in_valid = 0;
        os = (img + ws - 1) / ws;
        check("setup_busy", busy, 1);
        check("setup_errs_clr", {cfg_err, ovf_err}, 0);
        check("setup_not_ready", map_ready, 0);
        for (int k = 0; k < os; k++) tick();
        check("outSize", outSize, os);
    endtask

    task automatic capture();
        for (int i = 0; i < q.size(); i++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 0;
                tick();
            end
            in_valid = 1;
            in_data = q[i];
            model[i] = kept(q[i]);
            if (i == q.size() - 1) check("ready_before_last", map_ready, 0);
            tick();
        end
        in_valid = 0;
        check("map_ready", map_ready, 1);
        check("busy_done", busy, 0);
        check("no_ovf", ovf_err, 0);
    endtask

    task automatic fill_random();
        q = {};
        for (int i = 0; i < os * os; i++) q.push_back(16'($urandom));
    endtask

    task automatic read_at(input int a);
        logic [15:0] exp;
        exp = 16'd0;
        if (a < os * os) exp = model[a];
        rd_en = 1;
        rd_addr = 16'(a);
        tick();
        rd_en = 0;
        check("rd_valid", rd_valid, 1);
        check($sformatf("rd_data@%0d", a), rd_data, exp);
    endtask

    initial begin
        reset = 0;
        tick();
        check_all_zero("reset");
        reset = 1;
        tick();

        begin_map(4, 2);
        q = '{16'd10, 16'd20, 16'd30, 16'd40};
        capture();
        for (int a = 0; a < 4; a++) read_at(a);
        check("rd_data_10", model[0], 16'd10);
        tick();
        check("rd_valid_idle", rd_valid, 0);

        begin_map(5, 2);
        fill_random();
        capture();
        read_at(9);
        read_at(4);
        read_at(8);
        held = rd_data;

        imgSize = 4; windowSize = 0; start = 1;
        tick();
        start = 0;
        check("cfg_ws0", {cfg_err, busy, map_ready}, 3'b100);
        imgSize = 33; windowSize = 2; start = 1;
        tick();
        start = 0;
        check("cfg_img33", {cfg_err, busy, map_ready}, 3'b100);
        rd_en = 1; rd_addr = 0;
        tick();
        rd_en = 0;
        check("rd_not_ready_valid", rd_valid, 0);
        check("rd_not_ready_hold", rd_data, held);
        in_valid = 1; in_data = 16'h1234;
        tick();
        in_valid = 0;
        check("ovf_idle", ovf_err, 1);

        begin_map(4, 2);
        q = '{16'hFFFB, 16'd7, 16'hFFFF, 16'd0};
        capture();
        in_valid = 1; in_data = 16'h7777;
        tick();
        in_valid = 0;
        check("ovf_ready", ovf_err, 1);
        for (int a = 0; a < 4; a++) read_at(a);
`ifdef POOL_MAP_RELU_EN
        check("relu_neg", model[0], 16'd0);
`else
        check("verbatim_neg", model[0], 16'hFFFB);
`endif

        in_valid = 1; in_data = 16'h5555;
        begin_map(4, 2);
        check("start_beats_valid", ovf_err, 0);
        in_valid = 1; in_data = 16'd1;
        tick();
        in_data = 16'd2;
        tick();
        in_valid = 0;
        reset = 0;
        #1;
        check_all_zero("reset_mid");
        reset = 1;
        tick();
        begin_map(4, 2);
        q = '{16'd100, 16'd200, 16'd300, 16'd400};
        capture();
        for (int a = 0; a < 4; a++) read_at(a);

        for (int it = 0; it < 20; it++) begin
            begin_map($urandom_range(32, 1), $urandom_range(5, 1));
            fill_random();
            capture();
            for (int r = 0; r < 8; r++) read_at($urandom_range(os * os + 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
